// File: rtl/turbo_pkg.sv
// Shared turbo definitions used by the receive deframer and the encoder control FSM.
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int TAIL_LEN    = 3;
  localparam int CNT_W       = 14;
  localparam int K_LONG_DEF  = 6144;
  localparam int K_SHORT_DEF = 40;

  function automatic logic [CNT_W-1:0] sel_blk_len(input logic flag, input int k_long,
                                                   input int k_short);
    return flag ? CNT_W'(k_long) : CNT_W'(k_short);
  endfunction

endpackage

// File: rtl/turbo_rx_deframer.sv
// Turbo receive deframer: K data triples to the decoder buffer, 3 tail beats to registers.
// Optional build macro TURBO_RX_ERR_CNT_EN adds a saturating frame-error counter output.
module turbo_rx_deframer
  import turbo_pkg::*;
#(
  parameter int SW      = 4,
  parameter int K_LONG  = K_LONG_DEF,
  parameter int K_SHORT = K_SHORT_DEF,
  parameter int AW      = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_sof_i,
  input  logic            length_flag_i,
  input  logic [SW-1:0]   in_sys_i,
  input  logic [SW-1:0]   in_p1_i,
  input  logic [SW-1:0]   in_p2_i,
  input  logic            dec_free_i,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [3*SW-1:0] wr_data_o,
  output logic [3*SW-1:0] tail_sys_o,
  output logic [3*SW-1:0] tail_p1_o,
  output logic [3*SW-1:0] tail_p2_o,
  output logic [CNT_W-1:0] blk_len_o,
  output logic            block_done_o,
  output logic            busy_o,
`ifdef TURBO_RX_ERR_CNT_EN
  output logic [7:0]      err_cnt_o,
`endif
  output logic            frame_err_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  blk_len_q, blk_len_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [3*SW-1:0]   wr_data_q, wr_data_d;
  logic              ferr_q, ferr_d;
  logic              tail_we;
  logic [1:0]        tail_idx;
  logic              accept;
  logic [SW-1:0]     tsys_q [TAIL_LEN];
  logic [SW-1:0]     tp1_q  [TAIL_LEN];
  logic [SW-1:0]     tp2_q  [TAIL_LEN];

  assign accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // An accepted sof always starts a new block, whatever the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_len_d = blk_len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ferr_d    = 1'b0;
    tail_we   = 1'b0;
    tail_idx  = cnt_q[1:0];
    if (accept) begin
      if (in_sof_i) begin
        ferr_d    = (state_q == ST_DATA) || (state_q == ST_TAIL);
        state_d   = ST_DATA;
        cnt_d     = CNT_W'(1);
        blk_len_d = sel_blk_len(length_flag_i, K_LONG, K_SHORT);
        wr_en_d   = 1'b1;
        wr_addr_d = '0;
        wr_data_d = {in_p2_i, in_p1_i, in_sys_i};
      end else begin
        case (state_q)
          ST_DATA: begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(cnt_q);
            wr_data_d = {in_p2_i, in_p1_i, in_sys_i};
            if (cnt_q == blk_len_q - CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_TAIL;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_TAIL: begin
            tail_we = 1'b1;
            if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    in_ready_o   = 1'b0;
    busy_o       = 1'b0;
    block_done_o = 1'b0;
    if (!reset) begin
      busy_o       = (state_q == ST_DATA) || (state_q == ST_TAIL);
      in_ready_o   = busy_o ? 1'b1 : dec_free_i;
      block_done_o = (state_q == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      blk_len_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blk_len_q <= blk_len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAIL_LEN; i++) begin
        tsys_q[i] <= '0;
        tp1_q[i]  <= '0;
        tp2_q[i]  <= '0;
      end
    end else if (tail_we) begin
      tsys_q[tail_idx] <= in_sys_i;
      tp1_q[tail_idx]  <= in_p1_i;
      tp2_q[tail_idx]  <= in_p2_i;
    end
  end

  for (genvar g = 0; g < TAIL_LEN; g++) begin : g_tail
    assign tail_sys_o[g*SW +: SW] = tsys_q[g];
    assign tail_p1_o[g*SW +: SW]  = tp1_q[g];
    assign tail_p2_o[g*SW +: SW]  = tp2_q[g];
  end

`ifdef TURBO_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                               err_cnt_q <= '0;
    else if (ferr_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign err_cnt_o = err_cnt_q;
`endif

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign blk_len_o   = blk_len_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_turbo_rx_deframer.sv
// Scoreboard bench for turbo_rx_deframer: buffer writes are queued at drive time, popped on wr_en.
module tb_turbo_rx_deframer;

  localparam int SW = 4;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, length_flag = 1'b0, dec_free = 1'b1;
  logic [SW-1:0] in_sys = '0, in_p1 = '0, in_p2 = '0;
  logic in_ready, wr_en, block_done, busy, frame_err;
  logic [AW-1:0] wr_addr;
  logic [3*SW-1:0] wr_data, tail_sys, tail_p1, tail_p2;
  logic [13:0] blk_len;
`ifdef TURBO_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  turbo_rx_deframer dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_sof_i(in_sof), .length_flag_i(length_flag), .in_sys_i(in_sys), .in_p1_i(in_p1),
    .in_p2_i(in_p2), .dec_free_i(dec_free), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .tail_sys_o(tail_sys), .tail_p1_o(tail_p1), .tail_p2_o(tail_p2),
    .blk_len_o(blk_len), .block_done_o(block_done), .busy_o(busy),
`ifdef TURBO_RX_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [3*SW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  int obs_done = 0, obs_ferr = 0, exp_done = 0, exp_ferr = 0;
  logic [3*SW-1:0] exp_tsys, exp_tp1, exp_tp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  function automatic logic [3*SW-1:0] mk(input int seed, input int i);
    return 12'((i * 37 + seed * 101) ^ (i >> 2));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", {19'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {19'd0, wr_addr}, {19'd0, e.addr});
          chk("wr_data", {20'd0, wr_data}, {20'd0, e.data});
        end
      end
      if (block_done) obs_done++;
      if (frame_err)  obs_ferr++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic sof, input logic flag, input logic [3*SW-1:0] v);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_sof = sof; length_flag = flag;
    {in_p2, in_p1, in_sys} = v;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends beats 0..n-1 of a block of length k; data beats are queued as expected writes.
  task automatic send_block(input logic flag, input int k, input int seed, input int n,
                            input bit gap);
    logic [3*SW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = mk(seed, i);
      if (i < k) exp_q.push_back('{addr: AW'(i), data: v});
      else begin
        exp_tsys[(i-k)*SW +: SW] = v[SW-1:0];
        exp_tp1[(i-k)*SW +: SW]  = v[2*SW-1:SW];
        exp_tp2[(i-k)*SW +: SW]  = v[3*SW-1:2*SW];
      end
      send_beat(i == 0, flag, v);
      if (gap && (i % 2 == 1)) idle(1);
    end
    if (n == k + 3) exp_done++;
  endtask

  task automatic check_block(input int k);
    idle(3);
    chk("blk_len", {18'd0, blk_len}, k);
    chk("done_cnt", obs_done, exp_done);
    chk("ferr_cnt", obs_ferr, exp_ferr);
    chk("tail_sys", {20'd0, tail_sys}, {20'd0, exp_tsys});
    chk("tail_p1", {20'd0, tail_p1}, {20'd0, exp_tp1});
    chk("tail_p2", {20'd0, tail_p2}, {20'd0, exp_tp2});
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_blk_len", blk_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", block_done, 0);
    @(posedge clk); #1;

    // Continuous short block
    send_block(1'b0, 40, 1, 43, 1'b0);
    check_block(40);

    // Same block with a bubble every third cycle
    send_block(1'b0, 40, 1, 43, 1'b1);
    check_block(40);

    // Back-to-back blocks with zero bubble
    send_block(1'b0, 40, 2, 43, 1'b0);
    send_block(1'b0, 40, 3, 43, 1'b0);
    check_block(40);

    // sof reasserted at data beat 20 abandons the first block
    send_block(1'b0, 40, 4, 20, 1'b0);
    exp_ferr++;
    send_block(1'b0, 40, 5, 43, 1'b0);
    check_block(40);

    // Decoder buffer not free: the start beat must be held off
    dec_free = 1'b0;
    in_valid = 1'b1; in_sof = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    dec_free = 1'b1;
    send_block(1'b0, 40, 6, 43, 1'b0);
    check_block(40);

    // Stray non-sof beats in IDLE are discarded with a frame error each
    for (int i = 0; i < 3; i++) begin
      send_beat(1'b0, 1'b0, mk(7, i));
      exp_ferr++;
    end
    idle(3);
    chk("stray_ferr", obs_ferr, exp_ferr);
    chk("stray_busy", busy, 0);
`ifdef TURBO_RX_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_ferr);
`endif

    // Reset at tail beat 1 drops the block
    send_block(1'b0, 40, 8, 41, 1'b0);
    reset = 1'b1;
    in_valid = 1'b1; {in_p2, in_p1, in_sys} = mk(8, 41);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_blk_len", blk_len, 0);
    chk("rst_mid_ready", in_ready, 1);
    idle(3);
    chk("rst_mid_done", obs_done, exp_done);
`ifdef TURBO_RX_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif

    // Long block after reset
    send_block(1'b1, 6144, 9, 6147, 1'b0);
    check_block(6144);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
